// File: rtl/instr_fetch_queue_pkg.sv
// Core constants shared between the fetch queue and decode: XLEN, the
// canonical NOP encoding and the RV32I major opcodes.
package instr_fetch_queue_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

   // RV32I major opcodes (instr[6:0])
   localparam logic [6:0] OP_IMM = 7'b001_0011;
   localparam logic [6:0] LOAD   = 7'b000_0011;
   localparam logic [6:0] STORE  = 7'b010_0011;
   localparam logic [6:0] BRANCH = 7'b110_0011;
   localparam logic [6:0] JAL    = 7'b110_1111;
   localparam logic [6:0] JALR   = 7'b110_0111;
   localparam logic [6:0] LUI    = 7'b011_0111;
   localparam logic [6:0] AUIPC  = 7'b001_0111;
   localparam logic [6:0] SYSTEM = 7'b111_0011;

   // Extract the major opcode field of a 32-bit instruction word
   function automatic logic [6:0] get_opcode(input logic [31:0] instr);
      return instr[6:0];
   endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {fault, instr, pc} between
// the I-cache response and decode. Full/empty come from the occupancy
// counter only; flush empties the queue on the next edge.
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = instr_fetch_queue_pkg::XLEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [XLEN-1:0]          enq_pc,
   input  logic [XLEN-1:0]          enq_instr,
   input  logic                     enq_fault,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [XLEN-1:0]          deq_pc,
   output logic [XLEN-1:0]          deq_instr,
   output logic                     deq_fault,
   output logic [$clog2(DEPTH):0]   occupancy
);
   import instr_fetch_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = 2 * XLEN + 1;

   localparam logic [PTR_W-1:0] PTR_ZERO  = '0;
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [XLEN-1:0]  NOP_X     = XLEN'(NOP_INSTR);

   // Entry layout: {fault, instr, pc}
   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [ENT_W-1:0] head_s;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] occ_q, occ_d;
   logic             enq_fire_s;
   logic             deq_fire_s;

   assign enq_ready = (occ_q != DEPTH_CNT);
   assign occupancy = occ_q;

   // Next-state for pointers and occupancy; flush overrides any handshake
   always_comb begin
      enq_fire_s = enq_valid && (occ_q != DEPTH_CNT) && !flush;
      deq_fire_s = deq_ready && (occ_q != CNT_ZERO) && !flush;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q;
      if (flush) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         occ_d    = CNT_ZERO;
      end else begin
         // DEPTH is a power of two, so PTR_W-bit overflow is the wrap to 0
         if (enq_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (deq_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({enq_fire_s, deq_fire_s})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
         endcase
      end
   end

   // Control state: pointers and occupancy, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         occ_q    <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Entry storage: written on an accepted enqueue, never reset
   always_ff @(posedge clk) begin
      if (enq_fire_s) begin
         mem_q[wr_ptr_q] <= {enq_fault, enq_instr, enq_pc};
      end
   end

   // Head presentation; an empty queue shows a NOP with no fault
   always_comb begin
      head_s = mem_q[rd_ptr_q];
      if (occ_q != CNT_ZERO) begin
         deq_valid = 1'b1;
         deq_pc    = head_s[XLEN-1:0];
         deq_instr = head_s[2*XLEN-1:XLEN];
         deq_fault = head_s[2*XLEN];
      end else begin
         deq_valid = 1'b0;
         deq_pc    = '0;
         deq_instr = NOP_X;
         deq_fault = 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a hand-computed vector table,
// directed corner sequences and randomized traffic against a queue model.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_pc;
   logic [31:0] enq_instr;
   logic        enq_fault;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_pc;
   logic [31:0] deq_instr;
   logic        deq_fault;
   logic [2:0]  occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_pc(enq_pc), .enq_instr(enq_instr), .enq_fault(enq_fault),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_instr(deq_instr), .deq_fault(deq_fault),
      .occupancy(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an ordered list of held entries
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } ent_t;
   ent_t model_q[$];

   typedef struct {
      logic        fl;
      logic        ev;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ft;
      logic        dr;
      logic [2:0]  e_occ;
      logic        e_dv;
      logic        e_er;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_ft;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model's current contents
   task automatic check_model();
      int sz = model_q.size();
      chk("occupancy", 64'(occupancy), 64'(sz));
      chk("deq_valid", 64'(deq_valid), 64'(sz != 0));
      chk("enq_ready", 64'(enq_ready), 64'(sz != DEPTH));
      if (sz != 0) begin
         chk("deq_pc",    64'(deq_pc),    64'(model_q[0].pc));
         chk("deq_instr", 64'(deq_instr), 64'(model_q[0].instr));
         chk("deq_fault", 64'(deq_fault), 64'(model_q[0].fault));
      end else begin
         chk("deq_pc_empty",    64'(deq_pc),    64'h0);
         chk("deq_instr_empty", 64'(deq_instr), 64'(NOP));
         chk("deq_fault_empty", 64'(deq_fault), 64'h0);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, sample at the falling edge
   task automatic apply(input logic fl, input logic ev, input logic [31:0] pc,
                        input logic [31:0] instr, input logic ft, input logic dr);
      flush = fl; enq_valid = ev; enq_pc = pc; enq_instr = instr;
      enq_fault = ft; deq_ready = dr;
      @(negedge clk);
      check_model();
   endtask

   // Advance the model by the queue rules, then cross the rising edge
   task automatic commit();
      int  sz  = model_q.size();
      bit  enq = enq_valid && (sz < DEPTH);
      bit  deq = deq_ready && (sz > 0);
      ent_t e;
      if (flush) begin
         model_q.delete();
      end else begin
         if (deq) void'(model_q.pop_front());
         if (enq) begin
            e.pc = enq_pc; e.instr = enq_instr; e.fault = enq_fault;
            model_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic fl, input logic ev, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ft, input logic dr);
      apply(fl, ev, pc, instr, ft, dr);
      commit();
   endtask

   logic [31:0] last_pc;

   initial begin
      rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_pc = 32'h0;
      enq_instr = 32'h0; enq_fault = 1'b0; deq_ready = 1'b0;

      // Table: expected outputs are those seen during the row's cycle
      //          fl    ev    pc            instr          ft    dr    occ   dv    er    dpc           dinstr         dft
      vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        NOP,           1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h100,      32'h0050_0093, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h0,        NOP,           1'b0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 32'h100,      32'h0050_0093, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 32'h104,      32'h0000_0463, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 32'h100,      32'h0050_0093, 1'b0};
      vecs[4] = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 32'h104,      32'h0000_0463, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 32'h0,        32'h0,         1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 32'h0,        NOP,           1'b0};

      // Reset state while rst_n is held low
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_occupancy", 64'(occupancy), 64'h0);
      chk("rst_deq_valid", 64'(deq_valid), 64'h0);
      chk("rst_enq_ready", 64'(enq_ready), 64'h1);
      chk("rst_deq_instr", 64'(deq_instr), 64'(NOP));
      chk("rst_deq_fault", 64'(deq_fault), 64'h0);
      chk("rst_deq_pc",    64'(deq_pc),    64'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 6; i++) begin
         apply(vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].instr, vecs[i].ft, vecs[i].dr);
         chk("tbl_occ",   64'(occupancy), 64'(vecs[i].e_occ));
         chk("tbl_dv",    64'(deq_valid), 64'(vecs[i].e_dv));
         chk("tbl_er",    64'(enq_ready), 64'(vecs[i].e_er));
         chk("tbl_pc",    64'(deq_pc),    64'(vecs[i].e_pc));
         chk("tbl_instr", 64'(deq_instr), 64'(vecs[i].e_instr));
         chk("tbl_fault", 64'(deq_fault), 64'(vecs[i].e_ft));
         commit();
      end

      // Fill to DEPTH with decode stalled, offer a 5th, then drain in order
      for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 32'(i * 4), 32'h0000_0013 + 32'(i << 20), 1'b0, 1'b0);
      apply(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
      chk("full_enq_ready", 64'(enq_ready), 64'h0);
      chk("full_occupancy", 64'(occupancy), 64'h4);
      commit();
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
         chk("drain_order", 64'(deq_pc), 64'(i * 4));
         commit();
      end
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Two entries, then 10 cycles of simultaneous enq+deq across the wrap
      cyc(1'b0, 1'b1, 32'h1000, 32'h1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h1004, 32'h2, 1'b0, 1'b0);
      last_pc = 32'h0FFC;
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, 1'b1, 32'h1008 + 32'(i * 4), 32'(i + 3), 1'b0, 1'b1);
         chk("steady_occ", 64'(occupancy), 64'h2);
         chk("steady_pc_step", 64'(deq_pc), 64'(last_pc + 32'h4));
         last_pc = deq_pc;
         commit();
      end

      // Flush at occupancy 3 with a simultaneous enqueue
      cyc(1'b0, 1'b1, 32'h2000, 32'h5, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 32'h3000, 32'h6, 1'b0, 1'b1);
      chk("flush_cycle_occ", 64'(occupancy), 64'h3);
      commit();
      apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("post_flush_occ", 64'(occupancy), 64'h0);
      chk("post_flush_dv",  64'(deq_valid), 64'h0);
      commit();

      // Faulted entry between two good ones
      cyc(1'b0, 1'b1, 32'h1FC, 32'h0010_0093, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h200, 32'h0020_0093, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 32'h204, 32'h0030_0093, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
         chk("fault_tag", 64'(deq_fault), 64'(deq_pc == 32'h200));
         commit();
      end

      // Asynchronous reset pulse mid-stream
      cyc(1'b0, 1'b1, 32'h400, 32'h7, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h404, 32'h8, 1'b0, 1'b0);
      apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_occ", 64'(occupancy), 64'h0);
      chk("async_rst_dv",  64'(deq_valid), 64'h0);
      chk("async_rst_instr", 64'(deq_instr), 64'(NOP));
      model_q.delete();
      #1 rst_n = 1'b1;
      commit();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 19) == 0), 1'($urandom), $urandom, $urandom,
             1'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
